// File: rtl/pixel_centroid_if.sv
// Pixel stream into pixel_centroid and the centroid result coming back out.
interface pixel_centroid_if;
  logic        frame_start;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic [7:0]  threshold;
  logic [9:0]  cent_x;
  logic [9:0]  cent_y;
  logic [19:0] pix_count;
  logic        obj_found;
  logic        cent_valid;
  logic        busy;

  modport master (
    output frame_start, pix_valid, pix_data, threshold,
    input  cent_x, cent_y, pix_count, obj_found, cent_valid, busy
  );

  modport slave (
    input  frame_start, pix_valid, pix_data, threshold,
    output cent_x, cent_y, pix_count, obj_found, cent_valid, busy
  );
endinterface

// File: rtl/pixel_centroid.sv
// Centroid of above-threshold pixels over one frame: accumulate, divide, publish.
//   state  | meaning
//   IDLE   | waiting for frame_start
//   ACCUM  | sampling pixels, summing coordinates of pixels >= thr_q
//   DIVIDE | 32-step restoring divide of sum_x and sum_y by count
//   DONE   | one-cycle publish of the frame result (cent_valid follows)
module pixel_centroid #(
  parameter int IMG_W   = 648,
  parameter int IMG_H   = 488,
  parameter int MIN_PIX = 16
) (
  input  logic            clk,
  input  logic            reset,
  pixel_centroid_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;
  state_t state, state_nxt;

  logic [9:0]  x;
  logic [9:0]  y;
  logic [31:0] sum_x;
  logic [31:0] sum_y;
  logic [19:0] count;
  logic [7:0]  thr_q;
  logic [19:0] rem_x;
  logic [19:0] rem_y;
  logic [4:0]  div_cnt;

  logic [9:0]  cent_x_q;
  logic [9:0]  cent_y_q;
  logic [19:0] pix_count_q;
  logic        obj_found_q;
  logic        cent_valid_q;
  logic        busy_c;

  logic        start;
  logic        sample;
  logic        hit;
  logic        last_x;
  logic        last_pix;
  logic        obj_next;
  logic        obj_now;
  logic [19:0] count_inc;
  logic [20:0] dif_x;
  logic [20:0] dif_y;

  assign start     = bus.frame_start && (state != DIVIDE);
  assign sample    = (state == ACCUM) && bus.pix_valid && !bus.frame_start;
  assign hit       = sample && (bus.pix_data >= thr_q);
  assign last_x    = (x == 10'(IMG_W - 1));
  assign last_pix  = sample && last_x && (y == 10'(IMG_H - 1));
  assign count_inc = count + {19'd0, hit};
  assign obj_next  = (count_inc >= 20'(MIN_PIX));
  assign obj_now   = (count >= 20'(MIN_PIX));

  // Trial subtraction; since rem < count, bit 20 is exactly the borrow (quotient bit = ~borrow).
  assign dif_x = {rem_x, sum_x[31]} - {1'b0, count};
  assign dif_y = {rem_y, sum_y[31]} - {1'b0, count};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.frame_start) state_nxt = ACCUM;
      end
      ACCUM: begin
        busy_c = 1'b1;
        if (last_pix) state_nxt = obj_next ? DIVIDE : DONE;
      end
      DIVIDE: begin
        busy_c = 1'b1;
        if (div_cnt == 5'd0) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = bus.frame_start ? ACCUM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // sum_x/sum_y double as the dividend/quotient shift registers during DIVIDE.
  always_ff @(posedge clk) begin
    if (reset) begin
      x            <= '0;
      y            <= '0;
      sum_x        <= '0;
      sum_y        <= '0;
      count        <= '0;
      thr_q        <= '0;
      rem_x        <= '0;
      rem_y        <= '0;
      div_cnt      <= '0;
      cent_x_q     <= '0;
      cent_y_q     <= '0;
      pix_count_q  <= '0;
      obj_found_q  <= 1'b0;
      cent_valid_q <= 1'b0;
    end else begin
      cent_valid_q <= 1'b0;
      if (start) begin
        x       <= '0;
        y       <= '0;
        sum_x   <= '0;
        sum_y   <= '0;
        count   <= '0;
        rem_x   <= '0;
        rem_y   <= '0;
        div_cnt <= 5'd31;
        thr_q   <= bus.threshold;
      end else if (sample) begin
        if (hit) begin
          sum_x <= sum_x + {22'd0, x};
          sum_y <= sum_y + {22'd0, y};
        end
        count <= count_inc;
        if (last_x) begin
          x <= '0;
          y <= y + 10'd1;
        end else begin
          x <= x + 10'd1;
        end
      end else if (state == DIVIDE) begin
        sum_x   <= {sum_x[30:0], ~dif_x[20]};
        sum_y   <= {sum_y[30:0], ~dif_y[20]};
        rem_x   <= dif_x[20] ? {rem_x[18:0], sum_x[31]} : dif_x[19:0];
        rem_y   <= dif_y[20] ? {rem_y[18:0], sum_y[31]} : dif_y[19:0];
        div_cnt <= div_cnt - 5'd1;
      end

      if (state == DONE) begin
        cent_valid_q <= 1'b1;
        pix_count_q  <= count;
        obj_found_q  <= obj_now;
        if (obj_now) begin
          cent_x_q <= sum_x[9:0];
          cent_y_q <= sum_y[9:0];
        end
      end
    end
  end

  assign bus.cent_x     = cent_x_q;
  assign bus.cent_y     = cent_y_q;
  assign bus.pix_count  = pix_count_q;
  assign bus.obj_found  = obj_found_q;
  assign bus.cent_valid = cent_valid_q;
  assign bus.busy       = busy_c;
endmodule

// File: tb/tb_pixel_centroid.sv
// Scoreboard bench for pixel_centroid on an 8x4 image with a frame-level reference model.
module tb_pixel_centroid;
  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int MINP = 1;

  typedef struct {
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic [19:0] cnt;
    logic        obj;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  pixel_centroid_if bus();

  pixel_centroid #(.IMG_W(W), .IMG_H(H), .MIN_PIX(MINP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t       exp_q[$];
  logic [7:0] frame_px [NPIX];
  logic [9:0] held_cx = '0;
  logic [9:0] held_cy = '0;
  logic       last_obj = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] r_thr;
  int         r_mode;

  function automatic void check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Whole-frame reference: count, coordinate sums, integer division; centroid held if no object.
  function automatic exp_t model(input logic [7:0] thr);
    exp_t   e;
    longint sx = 0;
    longint sy = 0;
    longint n  = 0;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        if (frame_px[yy*W + xx] >= thr) begin
          sx += xx;
          sy += yy;
          n++;
        end
    e.cnt = 20'(n);
    e.obj = (n >= MINP);
    if (e.obj) begin
      held_cx = 10'(sx / n);
      held_cy = 10'(sy / n);
    end
    e.cx  = held_cx;
    e.cy  = held_cy;
    e.cyc = 0;
    return e;
  endfunction

  task automatic clear_frame(input logic [7:0] v);
    for (int i = 0; i < NPIX; i++) frame_px[i] = v;
  endtask

  task automatic set_px(input int px, input int py, input logic [7:0] v);
    frame_px[py*W + px] = v;
  endtask

  task automatic drive(input logic fs, input logic pv, input logic [7:0] pd, input logic [7:0] th);
    bus.frame_start = fs;
    bus.pix_valid   = pv;
    bus.pix_data    = pd;
    bus.threshold   = th;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
  endtask

  // n_pix < NPIX sends a truncated frame; gaps also scrambles threshold mid-frame.
  task automatic send_frame(input logic [7:0] thr, input int n_pix, input bit expect_it, input bit gaps);
    exp_t e;
    drive(1'b1, 1'($urandom_range(0, 1)), 8'hff, thr);
    for (int i = 0; i < n_pix; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 8'($urandom), 8'($urandom));
      drive(1'b0, 1'b1, frame_px[i], gaps ? 8'($urandom) : thr);
    end
    if (expect_it && n_pix == NPIX) begin
      e = model(thr);
      e.cyc = cyc + (e.obj ? 33 : 1);
      exp_q.push_back(e);
      last_obj = e.obj;
    end
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("queue_drained", exp_q.size(), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cent_x"},     bus.cent_x,     0);
    check({tag, "_cent_y"},     bus.cent_y,     0);
    check({tag, "_pix_count"},  bus.pix_count,  0);
    check({tag, "_obj_found"},  bus.obj_found,  0);
    check({tag, "_cent_valid"}, bus.cent_valid, 0);
    check({tag, "_busy"},       bus.busy,       0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.cent_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cent_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("latency",   cyc,           e.cyc);
          check("cent_x",    bus.cent_x,    e.cx);
          check("cent_y",    bus.cent_y,    e.cy);
          check("pix_count", bus.pix_count, e.cnt);
          check("obj_found", bus.obj_found, e.obj);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = '0;
    bus.threshold   = '0;
    fork
      monitor();
    join_none

    idle_cycles(3);
    check_all_zero("reset");
    reset = 1'b0;
    idle_cycles(2);

    // single bright pixel
    clear_frame(8'd0);
    set_px(5, 2, 8'd200);
    send_frame(8'd100, NPIX, 1, 1);
    check("busy_divide", bus.busy, 1);
    wait_drain();
    check("busy_idle", bus.busy, 0);

    // dark frame keeps the previous centroid
    clear_frame(8'd50);
    send_frame(8'd100, NPIX, 1, 1);
    wait_drain();

    // two bright pixels, truncating division
    clear_frame(8'd0);
    set_px(2, 1, 8'd150);
    set_px(5, 3, 8'd150);
    send_frame(8'd100, NPIX, 1, 1);
    wait_drain();

    // threshold boundary
    clear_frame(8'd0);
    set_px(0, 0, 8'd100);
    set_px(1, 0, 8'd99);
    set_px(7, 3, 8'd100);
    set_px(3, 2, 8'd99);
    set_px(6, 1, 8'd101);
    send_frame(8'd100, NPIX, 1, 1);
    wait_drain();

    // restart after 10 pixels
    clear_frame(8'd200);
    send_frame(8'd100, 10, 0, 0);
    check("busy_accum", bus.busy, 1);
    clear_frame(8'd30);
    set_px(7, 0, 8'd120);
    set_px(0, 3, 8'd100);
    send_frame(8'd100, NPIX, 1, 1);
    wait_drain();

    // reset in the 16th divide cycle
    clear_frame(8'd0);
    set_px(3, 3, 8'd255);
    set_px(6, 1, 8'd180);
    send_frame(8'd100, NPIX, 0, 0);
    idle_cycles(15);
    reset = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    held_cx = '0;
    held_cy = '0;
    check_all_zero("abort");
    idle_cycles(40);

    // a full frame issued during DIVIDE is dropped
    clear_frame(8'd10);
    set_px(1, 3, 8'd200);
    send_frame(8'd100, NPIX, 1, 0);
    clear_frame(8'd250);
    send_frame(8'd100, NPIX, 0, 0);
    wait_drain();
    idle_cycles(40);

    // randomized frames; after a no-object frame sometimes start the next one straight out of DONE
    for (int f = 0; f < 24; f++) begin
      r_thr  = 8'($urandom_range(1, 255));
      r_mode = $urandom_range(0, 2);
      for (int i = 0; i < NPIX; i++) begin
        case (r_mode)
          0:       frame_px[i] = 8'($urandom_range(0, int'(r_thr) - 1));
          1:       frame_px[i] = 8'($urandom);
          default: frame_px[i] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(int'(r_thr), 255))
                                                              : 8'($urandom_range(0, int'(r_thr) - 1));
        endcase
      end
      send_frame(r_thr, NPIX, 1, 1);
      if (last_obj || $urandom_range(0, 1) == 1) wait_drain();
    end
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pixel_centroid.md
PIXEL_CENTROID -- requirements
Module: pixel_centroid

Interface
REQ-001 Parameter IMG_W, default 648, pixels per line.
REQ-002 Parameter IMG_H, default 488, lines per frame.
REQ-003 Parameter MIN_PIX, default 16, minimum above-threshold pixel count for a valid object.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 frame_start  input  1  one-cycle pulse marking the start of a new frame.
REQ-007 pix_valid  input  1  pix_data valid this cycle.
REQ-008 pix_data  input  8  pixel intensity, the upper 8 bits of the CVM300 10-bit sample.
REQ-009 threshold  input  8  intensity threshold for object pixels.
REQ-010 cent_x  output  10  object centroid column.
REQ-011 cent_y  output  10  object centroid row.
REQ-012 pix_count  output  20  above-threshold pixel count of the last completed frame.
REQ-013 obj_found  output  1  last completed frame had pix_count >= MIN_PIX.
REQ-014 cent_valid  output  1  one-cycle pulse when the outputs above update.
REQ-015 busy  output  1  high in ACCUM or DIVIDE.

Function
REQ-016 The FSM SHALL have states IDLE, ACCUM, DIVIDE and DONE.
REQ-017 On frame_start in IDLE, ACCUM or DONE, the block SHALL perform all of the following, then enter ACCUM:
- clear x, y, sum_x, sum_y and count;
- latch threshold into thr_q.
REQ-018 In ACCUM, each pix_valid cycle SHALL sample one pixel at (x,y).
REQ-019 For each sampled pixel with pix_data >= thr_q, the block SHALL update the accumulators:
- sum_x += x;
- sum_y += y;
- count += 1.
REQ-020 x SHALL increment per sampled pixel.
REQ-021 At x == IMG_W-1, x SHALL wrap to 0 and y SHALL increment.
REQ-022 sum_x and sum_y SHALL be 32 bits; count SHALL be 20 bits; no overflow is possible at the default parameters.
REQ-023 Sampling the pixel at (IMG_W-1, IMG_H-1) SHALL end the frame.
REQ-024 At frame end, the next state SHALL be DIVIDE if count >= MIN_PIX, else DONE.
REQ-025 DIVIDE SHALL run two restoring dividers in parallel, sum_x/count and sum_y/count, for exactly 32 cycles, then enter DONE.
REQ-026 Quotients SHALL be truncated toward zero; cent_x and cent_y take the low 10 bits.
REQ-027 DONE SHALL last one cycle, then return to IDLE. During DONE, the block SHALL:
- assert cent_valid;
- update pix_count and obj_found.
REQ-028 In DONE, cent_x and cent_y SHALL update only if obj_found=1; otherwise they hold their previous values.
REQ-029 Resulting latency: cent_valid SHALL be high 33 cycles after the last-pixel edge when obj_found=1, and 1 cycle after when obj_found=0.
REQ-030 frame_start in ACCUM SHALL restart the frame; the partial frame is discarded with no cent_valid.
REQ-031 frame_start and pix_valid in the same cycle: frame_start SHALL win, and that pixel is not sampled.
REQ-032 In DIVIDE, frame_start and pix_valid SHALL be ignored; that frame is dropped.
REQ-033 In IDLE and DONE, pix_valid without frame_start SHALL be ignored.
REQ-034 threshold changes mid-frame SHALL have no effect until the next frame_start.

Reset
REQ-035 On reset, the block SHALL enter IDLE and clear all of:
- cent_x, cent_y, pix_count, obj_found, cent_valid, busy;
- all accumulators, counters and divider registers.
REQ-036 reset SHALL take priority over every other input, including mid-ACCUM and mid-DIVIDE; no cent_valid is produced for the aborted frame.

Verification (IMG_W=8, IMG_H=4, MIN_PIX=1, threshold=100)
REQ-037 Single bright pixel: frame with only (5,2)=200 -> cent_valid 33 cycles after last pixel; cent_x=5, cent_y=2, pix_count=1, obj_found=1.
REQ-038 Two bright pixels: (2,1)=150 and (5,3)=150 -> cent_x=3 (7/2 truncated), cent_y=2, pix_count=2.
REQ-039 Dark frame: all pixels 50 after REQ-037 -> cent_valid 1 cycle after last pixel; obj_found=0, pix_count=0, cent_x=5 and cent_y=2 held.
REQ-040 Boundary pixels: exactly 100 counted, 99 not counted -> pix_count reflects only pixels >= 100.
REQ-041 Restart and abort:
- frame_start after 10 pixels -> no cent_valid; the next full frame reports only its own pixels.
- reset during DIVIDE cycle 16 -> all outputs 0, IDLE, no cent_valid.
REQ-042 Ignored frame: frame_start plus a full frame during DIVIDE -> ignored; exactly one cent_valid, for the first frame.
